// File: rtl/rf_writeback_pkg.sv
// Shared widths, pointer type and write-request record for the register-file write-back path.
package rf_writeback_pkg;
  localparam int PTR_W     = 5;
  localparam int DATA_W    = 8;
  localparam int LDQ_DEPTH = 4;
  localparam int LDQ_AW    = $clog2(LDQ_DEPTH);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    ptr_t  dest;
    data_t data;
    logic  ovf;
  } wb_req_t;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic ptr_hit(input ptr_t chk, input ptr_t dest);
    return (chk != '0) && (chk == dest);
  endfunction
endpackage

// File: rtl/rf_writeback_ldq_fifo.sv
// In-order tag FIFO of outstanding load destinations; exposes every slot plus a valid mask
// so the parent can hazard-check all pending loads at once.
module ldq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [DEPTH*W-1:0]       o_entries,
  output logic [DEPTH-1:0]         o_entry_vld
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rptr];

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    o_entries   = '0;
    o_entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i*W +: W] = r_mem[i];
      o_entry_vld[i]      = ({1'b0, AW'(AW'(i) - r_rptr)} < r_cnt);
    end
  end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write sequencer: merges ALU results with in-order load returns, flags
// read-after-load hazards and keeps sticky overflow/error flags. Option: RF_WB_BYPASS_EN.
module rf_writeback
  import rf_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [PTR_W-1:0]  alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_ovf,
  input  logic              ld_issue,
  input  logic [PTR_W-1:0]  ld_dest,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              ovf_clr,
  input  logic [PTR_W-1:0]  chk_a,
  input  logic [PTR_W-1:0]  chk_b,
  output logic [DATA_W-1:0] di,
  output logic              we,
  output logic [PTR_W-1:0]  ptr_w,
  output logic              r_overflow,
  output logic              stall,
  output logic              hazard,
`ifdef RF_WB_BYPASS_EN
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              wb_err
);
  wb_req_t                    r_skid;
  logic                       r_skid_vld;
  wb_req_t                    r_wr;
  logic                       r_we;
  logic                       r_err;

  logic [PTR_W-1:0]           w_head;
  logic                       w_full;
  logic                       w_empty;
  logic [LDQ_AW:0]            w_count;
  logic [LDQ_DEPTH*PTR_W-1:0] w_entries;
  logic [LDQ_DEPTH-1:0]       w_entry_vld;

  logic                       w_stall;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_alu_acc;
  wb_req_t                    w_alu_req;
  wb_req_t                    w_commit;
  logic                       w_commit_vld;
  logic                       w_to_skid;
  logic                       w_skid_drain;
  logic                       w_hit_a;
  logic                       w_hit_b;

  ldq_fifo #(
    .DEPTH (LDQ_DEPTH),
    .W     (PTR_W)
  ) u_ldq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_dat  (ld_dest),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_entries   (w_entries),
    .o_entry_vld (w_entry_vld)
  );

  assign w_stall   = r_skid_vld | (w_count == (LDQ_AW+1)'(LDQ_DEPTH));
  assign w_pop     = mem_valid & ~w_empty;
  assign w_push    = ld_issue & ~r_skid_vld & (~w_full | w_pop);
  assign w_alu_acc = alu_valid & ~w_stall;
  assign w_alu_req = '{dest: alu_dest, data: alu_data, ovf: alu_ovf};

  // Load returns cannot stall, so they always win; a displaced ALU result parks in the skid.
  always_comb begin
    w_commit     = '0;
    w_commit_vld = 1'b0;
    w_to_skid    = 1'b0;
    w_skid_drain = 1'b0;
    if (w_pop) begin
      w_commit     = '{dest: w_head, data: mem_data, ovf: 1'b0};
      w_commit_vld = 1'b1;
      w_to_skid    = w_alu_acc;
    end else if (r_skid_vld) begin
      w_commit     = r_skid;
      w_commit_vld = 1'b1;
      w_skid_drain = 1'b1;
    end else if (w_alu_acc) begin
      w_commit     = w_alu_req;
      w_commit_vld = 1'b1;
    end
  end

  // The write register's ovf field doubles as the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_wr       <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_to_skid) begin
        r_skid     <= w_alu_req;
        r_skid_vld <= 1'b1;
      end else if (w_skid_drain) begin
        r_skid_vld <= 1'b0;
      end
      r_we <= w_commit_vld & (w_commit.dest != '0);
      if (w_commit_vld) begin
        r_wr.dest <= w_commit.dest;
        r_wr.data <= w_commit.data;
      end
      if (w_commit_vld & w_commit.ovf) r_wr.ovf <= 1'b1;
      else if (ovf_clr)                r_wr.ovf <= 1'b0;
      if ((mem_valid & w_empty) | (ld_issue & w_full & ~w_pop)) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      if (w_entry_vld[i]) begin
        w_hit_a = w_hit_a | ptr_hit(chk_a, w_entries[i*PTR_W +: PTR_W]);
        w_hit_b = w_hit_b | ptr_hit(chk_b, w_entries[i*PTR_W +: PTR_W]);
      end
    end
    if (r_skid_vld) begin
      w_hit_a = w_hit_a | ptr_hit(chk_a, r_skid.dest);
      w_hit_b = w_hit_b | ptr_hit(chk_b, r_skid.dest);
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd_a    = r_we & (r_wr.dest == chk_a);
  assign fwd_b    = r_we & (r_wr.dest == chk_b);
  assign fwd_data = r_wr.data;
  assign hazard   = w_hit_a | w_hit_b;
`else
  // Without forwarding, the write still landing this cycle must also hold decode.
  assign hazard   = w_hit_a | w_hit_b |
                    (r_we & (ptr_hit(chk_a, r_wr.dest) | ptr_hit(chk_b, r_wr.dest)));
`endif

  assign di         = r_wr.data;
  assign we         = r_we;
  assign ptr_w      = r_wr.dest;
  assign r_overflow = r_wr.ovf;
  assign stall      = w_stall;
  assign wb_err     = r_err;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed plus randomized bench for rf_writeback against a queue-based reference model.
module tb_rf_writeback;
  import rf_writeback_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, alu_valid, alu_ovf, ld_issue, mem_valid, ovf_clr;
  logic [PTR_W-1:0]  alu_dest, ld_dest, chk_a, chk_b, ptr_w;
  logic [DATA_W-1:0] alu_data, mem_data, di;
  logic              we, r_overflow, stall, hazard, wb_err;
`ifdef RF_WB_BYPASS_EN
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] fwd_data;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ovf(alu_ovf),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .ovf_clr(ovf_clr), .chk_a(chk_a), .chk_b(chk_b),
    .di(di), .we(we), .ptr_w(ptr_w), .r_overflow(r_overflow),
    .stall(stall), .hazard(hazard),
`ifdef RF_WB_BYPASS_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data(fwd_data),
`endif
    .wb_err(wb_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending load dests in a queue, one parked ALU result, expected outputs.
  logic [PTR_W-1:0]  m_q[$];
  bit                m_skid_vld;
  logic [PTR_W-1:0]  m_skid_dest;
  logic [DATA_W-1:0] m_skid_data;
  bit                m_skid_ovf;
  bit                m_we, m_ovf, m_err;
  logic [PTR_W-1:0]  m_ptr;
  logic [DATA_W-1:0] m_di;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall();
    return m_skid_vld || (m_q.size() == LDQ_DEPTH);
  endfunction

  function automatic bit m_pending(input logic [PTR_W-1:0] r);
    if (r == '0) return 1'b0;
    foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
    if (m_skid_vld && m_skid_dest == r) return 1'b1;
    if (!BYP && m_we && m_ptr == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_skid_vld = 0; m_skid_dest = '0; m_skid_data = '0; m_skid_ovf = 0;
    m_we = 0; m_ovf = 0; m_err = 0; m_ptr = '0; m_di = '0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic m_cycle();
    bit pop, full, alu_ok, skid_before, ovf_set;
    logic [PTR_W-1:0] head;
    pop         = mem_valid && (m_q.size() != 0);
    full        = (m_q.size() == LDQ_DEPTH);
    alu_ok      = alu_valid && !m_stall();
    skid_before = m_skid_vld;
    ovf_set     = 0;
    if (mem_valid && !pop) m_err = 1;
    if (ld_issue && full && !pop) m_err = 1;
    m_we = 0;
    if (pop) begin
      head = m_q.pop_front();
      m_we = (head != '0); m_ptr = head; m_di = mem_data;
      if (alu_ok) begin
        m_skid_vld = 1; m_skid_dest = alu_dest; m_skid_data = alu_data; m_skid_ovf = alu_ovf;
      end
    end else if (m_skid_vld) begin
      m_we = (m_skid_dest != '0); m_ptr = m_skid_dest; m_di = m_skid_data;
      ovf_set = m_skid_ovf; m_skid_vld = 0;
    end else if (alu_ok) begin
      m_we = (alu_dest != '0); m_ptr = alu_dest; m_di = alu_data; ovf_set = alu_ovf;
    end
    if (ld_issue && !skid_before && (!full || pop)) m_q.push_back(ld_dest);
    if (ovf_clr) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
  endtask

  task automatic check_outputs();
    chk("we", 32'(we), 32'(m_we));
    chk("ptr_w", 32'(ptr_w), 32'(m_ptr));
    chk("di", 32'(di), 32'(m_di));
    chk("r_overflow", 32'(r_overflow), 32'(m_ovf));
    chk("wb_err", 32'(wb_err), 32'(m_err));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("hazard", 32'(hazard), 32'(m_pending(chk_a) | m_pending(chk_b)));
`ifdef RF_WB_BYPASS_EN
    chk("fwd_a", 32'(fwd_a), 32'(m_we && m_ptr == chk_a));
    chk("fwd_b", 32'(fwd_b), 32'(m_we && m_ptr == chk_b));
    chk("fwd_data", 32'(fwd_data), 32'(m_di));
`endif
  endtask

  task automatic step();
    m_cycle();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; ld_issue = 0; mem_valid = 0; ovf_clr = 0; alu_ovf = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    m_clear();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ptr_w", 32'(ptr_w), 32'd0);
    chk("rst_di", 32'(di), 32'd0);
    chk("rst_ovf", 32'(r_overflow), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic alu(input int d, input int v, input bit o);
    alu_valid = 1; alu_dest = PTR_W'(d); alu_data = DATA_W'(v); alu_ovf = o;
  endtask

  initial begin
    rst_n = 0; chk_a = '0; chk_b = '0;
    alu_dest = '0; alu_data = '0; ld_dest = '0; mem_data = '0;
    idle();
    m_clear();
    do_reset();

    // Uncontested ALU write.
    alu(3, 'h5A, 0); step();
    chk("alu_we", 32'(we), 32'd1); chk("alu_ptr", 32'(ptr_w), 32'd3); chk("alu_di", 32'(di), 32'h5A);
    idle(); step();
    chk("alu_we_drop", 32'(we), 32'd0);

    // Load return collides with an ALU result.
    ld_issue = 1; ld_dest = 2; step();
    idle(); step();
    mem_valid = 1; mem_data = 'h11; alu(4, 'h22, 0); step();
    chk("col_ptr1", 32'(ptr_w), 32'd2); chk("col_di1", 32'(di), 32'h11); chk("col_stall1", 32'(stall), 32'd1);
    idle(); step();
    chk("col_ptr2", 32'(ptr_w), 32'd4); chk("col_di2", 32'(di), 32'h22); chk("col_stall2", 32'(stall), 32'd0);

    // Fill the load queue, hazard on a pending dest, drain in order.
    for (int i = 1; i <= 4; i++) begin
      idle(); ld_issue = 1; ld_dest = PTR_W'(i); step();
    end
    idle(); chk_a = 3; #1;
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_hazard", 32'(hazard), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(); mem_valid = 1; mem_data = DATA_W'(8'h30 + i); step();
      chk("drain_ptr", 32'(ptr_w), 32'(i));
    end
    chk("drain_hazard", 32'(hazard), 32'd0);
    chk_a = 0; idle(); step();

    // Protocol errors.
    mem_valid = 1; mem_data = 'hEE; step();
    chk("err_no_we", 32'(we), 32'd0); chk("err_set", 32'(wb_err), 32'd1);
    for (int i = 9; i <= 12; i++) begin
      idle(); ld_issue = 1; ld_dest = PTR_W'(i); step();
    end
    idle(); ld_issue = 1; ld_dest = 13; step();
    chk("err_sticky", 32'(wb_err), 32'd1); chk("err_full", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(); mem_valid = 1; mem_data = DATA_W'($urandom); step();
    end
    chk("err_count4", 32'(stall), 32'd0);
    do_reset();

    // Overflow and register 0.
    alu(0, 'h77, 1); step();
    chk("r0_we", 32'(we), 32'd0); chk("r0_ovf", 32'(r_overflow), 32'd1);
    idle(); ovf_clr = 1; step();
    chk("ovf_clr", 32'(r_overflow), 32'd0);
    alu(7, 'h01, 1); ovf_clr = 1; step();
    chk("ovf_set_wins", 32'(r_overflow), 32'd1);
    idle(); step();

    // In-flight write seen by decode.
    alu(5, 'h6C, 0); chk_b = 5; step();
`ifdef RF_WB_BYPASS_EN
    chk("byp_fwd_b", 32'(fwd_b), 32'd1); chk("byp_data", 32'(fwd_data), 32'h6C);
`else
    chk("byp_hazard", 32'(hazard), 32'd1);
`endif
    chk_b = 0; idle(); step();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      idle();
      alu_valid = 1'($urandom_range(0, 1));
      alu_dest  = PTR_W'($urandom_range(0, 7));
      alu_data  = DATA_W'($urandom);
      alu_ovf   = ($urandom_range(0, 3) == 0);
      ld_issue  = (m_q.size() < LDQ_DEPTH) && ($urandom_range(0, 2) == 0);
      ld_dest   = PTR_W'($urandom_range(0, 7));
      mem_valid = (m_q.size() != 0) && ($urandom_range(0, 2) == 0);
      mem_data  = DATA_W'($urandom);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      chk_a     = PTR_W'($urandom_range(0, 7));
      chk_b     = PTR_W'($urandom_range(0, 7));
      step();
    end

    // Reset with a load outstanding discards it.
    idle(); ld_issue = 1; ld_dest = 6; chk_a = 6; step();
    chk("pre_rst_hazard", 32'(hazard), 32'd1);
    do_reset();
    chk_a = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side sequencer for the 8-bit core's register file: owns the `di`/`we`/`ptr_w`/`r_overflow` inputs of the register file and is the only block that drives them. Merges single-cycle ALU results with variable-latency, in-order data-memory load returns. Tracks outstanding load destinations to flag read-after-load hazards to decode, and holds a sticky overflow flag. Sits between execute/memory and the register file.

## Interface
- `PTR_W`, 5: register pointer width.
- `DATA_W`, 8: data width.
- `LDQ_DEPTH`, 4: outstanding-load tag queue depth, a power of 2 and at least 2.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_dest` in PTR_W: ALU destination register.
- `alu_data` in DATA_W: ALU result.
- `alu_ovf` in 1: ALU overflow for this result.
- `ld_issue` in 1: load issued to memory this cycle.
- `ld_dest` in PTR_W: destination register of the issued load.
- `mem_valid` in 1: load data returning this cycle; returns are in issue order and cannot be stalled.
- `mem_data` in DATA_W: returned load data.
- `ovf_clr` in 1: clear sticky overflow.
- `chk_a`, `chk_b` in PTR_W: decode read pointers to hazard-check.
- `di` out DATA_W: register-file write data (registered).
- `we` out 1: register-file write enable (registered).
- `ptr_w` out PTR_W: register-file write pointer (registered).
- `r_overflow` out 1: sticky overflow (registered).
- `stall` out 1: upstream must hold ALU and load issue (combinational from state).
- `hazard` out 1: `chk_a` or `chk_b` is nonzero and matches a pending destination.
- `wb_err` out 1: sticky protocol-error flag.

## Operation
- Load tag queue is a FIFO of `ld_dest` values. `ld_issue` pushes. `mem_valid` pops the head and produces a write of `mem_data` to the popped dest.
- ALU skid register holds one entry: dest, data, ovf.
- `stall` = skid occupied OR queue count equals `LDQ_DEPTH`.
- `alu_valid` and `ld_issue` are ignored while `stall` is high. An ignored `ld_issue` with a full queue and no simultaneous pop sets `wb_err`.
- Write arbitration per cycle, highest priority first:
  1. Load return.
  2. Skid entry.
  3. New ALU result.
- The losing ALU result goes into the skid register. A skid entry commits on the first cycle with no `mem_valid`.
- A write to register 0 commits with `we`=0. Its overflow is still captured.
- `r_overflow` is set when an ALU result with `alu_ovf`=1 commits. It is cleared by `ovf_clr`. Set wins over simultaneous clear.
- `mem_valid` with an empty queue sets `wb_err`, drops the data, and produces no write.
- Simultaneous push and pop is legal when full: the pop frees the slot, and the count is unchanged.
- The pending set comprises all queue entries and the skid entry. `hazard` compares `chk_a`/`chk_b` against that pending set.

## Timing
- Reset: `di`=0, `we`=0, `ptr_w`=0, `r_overflow`=0, `wb_err`=0. Queue and skid are empty, so `stall`=0 and `hazard`=0. Reset mid-operation discards all pending loads and skid contents.
- Latency:
  - ALU result to `we`: 1 cycle if uncontested.
  - ALU result to `we` after losing to a load return: at least 2 cycles.
  - `mem_valid` to `we`: 1 cycle, always.
- `we` is high for exactly one cycle per committed nonzero-dest write. At most one write per cycle.
- Queue pointers are `log2(LDQ_DEPTH)` bits and wrap modulo depth. The count is one bit wider.
- `stall` and `hazard` depend only on registered state and the current `chk_*` inputs, never on `alu_valid` or `mem_valid`.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - Adds outputs `fwd_a`, `fwd_b` (1 bit each) and `fwd_data` (DATA_W).
  - `fwd_a`/`fwd_b` assert when the registered write currently on `ptr_w` with `we`=1 matches `chk_a`/`chk_b`.
  - `fwd_data` = `di`.
  - The in-flight write is not counted as a hazard.
- Not defined:
  - The ports are absent.
  - `hazard` also asserts when a nonzero `chk_a`/`chk_b` equals `ptr_w` while `we`=1.

## Structure
- A shared package holds `PTR_W`, `DATA_W`, `LDQ_DEPTH` defaults, a `ptr_t` typedef, and a packed `wb_req_t` struct (dest, data, ovf) used for the skid entry and the write register.
- Sub-module `ldq_fifo`: parameterised tag FIFO with push, pop, full, empty, count, and a flat view of valid entries for hazard compare. Everything else lives in `rf_writeback`.

## Test plan
- ALU write: reset, then `alu_valid`, dest 3, data 0x5A -> next cycle `we`=1, `ptr_w`=3, `di`=0x5A; following cycle `we`=0.
- Collision: `ld_issue` dest 2; later `mem_valid` data 0x11 in the same cycle as an ALU result to dest 4, data 0x22 -> cycle+1 writes r2=0x11 with `stall`=1; cycle+2 writes r4=0x22 with `stall`=0.
- Queue full: 4 `ld_issue` to r1..r4 -> `stall`=1. Holding `chk_a`=3 gives `hazard`=1. Four `mem_valid` returns write r1..r4 in order, then `hazard`=0.
- Errors: `mem_valid` with empty queue -> no `we`, `wb_err`=1. A fifth `ld_issue` while full and not popping -> `wb_err` stays 1 and count stays 4.
- Overflow and r0: ALU dest 0 with `alu_ovf`=1 -> `we` stays 0, `r_overflow`=1. `ovf_clr` -> 0. `ovf_clr` together with a committing ovf result -> stays 1.
- Bypass: ALU write to r5, then `chk_b`=5 in the commit cycle -> `fwd_b`=1 and `fwd_data` = data with `RF_WB_BYPASS_EN` defined; without the macro, `hazard`=1.
